adder_issue_stage: RTL

ADDER_ISSUE_STAGE -- requirements
Module: adder_issue_stage

---
 rtl/adder_issue_stage.sv | 137 +++++++++++++
 1 files changed

// File: rtl/adder_issue_stage.sv
// Issue stage for an external 64-bit adder: registers operands, waits SETTLE_CYCLES, captures the result.
// Optional macro ADDER_OVF_EN adds the registered signed-overflow output out_V.
module adder_issue_stage #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_A,
    input  logic [63:0] in_B,
    input  logic        in_Cin,
    input  logic        in_sub,
    output logic [63:0] A,
    output logic [63:0] B,
    output logic        Cin,
    input  logic [63:0] Sum,
    input  logic        Cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_Sum,
    output logic        out_Cout
`ifdef ADDER_OVF_EN
    ,
    output logic        out_V
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [63:0] r_A;
    logic [63:0] r_B;
    logic        r_cin;
    logic [63:0] r_sum;
    logic        r_cout;
    logic        w_accept;
    logic        w_capture;

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt == 4'd0) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= CNT_INIT;
        end else if (r_state == SETTLE && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Subtract is A + ~B + 1, so the adder itself never needs to know the op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_A   <= 64'd0;
            r_B   <= 64'd0;
            r_cin <= 1'b0;
        end else if (w_accept) begin
            r_A   <= in_A;
            r_B   <= in_sub ? ~in_B : in_B;
            r_cin <= in_sub | in_Cin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= 64'd0;
            r_cout <= 1'b0;
        end else if (w_capture) begin
            r_sum  <= Sum;
            r_cout <= Cout;
        end
    end

`ifdef ADDER_OVF_EN
    logic r_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= 1'b0;
        end else if (w_capture) begin
            r_v <= (r_A[63] == r_B[63]) && (Sum[63] != r_A[63]);
        end
    end

    assign out_V = r_v;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign A         = r_A;
    assign B         = r_B;
    assign Cin       = r_cin;
    assign out_Sum   = r_sum;
    assign out_Cout  = r_cout;

endmodule
